// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: owns the 10-slot obstacle table. On each frame tick during
// play it scrolls and retires the slots one per cycle, then may spawn one new
// obstacle whose height and placement (ceiling or floor) come from an LFSR.
// Optional build macro: OBSTACLE_SPEEDUP_EN (scroll speed grows with spawns).
module obstacle_scheduler #(
  parameter int          SPAWN_X        = 600,
  parameter int          OBS_W          = 40,
  parameter int          UPPER_BOUND    = 120,
  parameter int          LOWER_BOUND    = 360,
  parameter int          OBS_H_MIN      = 40,
  parameter int          SPEED          = 4,
  parameter int          SPAWN_INTERVAL = 60,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          SPEEDUP_SPAWNS = 8,
  parameter int          MAX_SPEED      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_tick,
  input  logic [1:0]   gamemode,
  output logic [199:0] obstacle_x,
  output logic [179:0] obstacle_y,
  output logic         busy,
  output logic [3:0]   active_count,
  output logic         overrun,
  output logic [15:0]  spawned_total
);

  localparam int         NUM_SLOTS   = 10;
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SCAN        = 2'd1;
  localparam logic [1:0] SPAWN       = 2'd2;
  localparam logic [1:0] GM_INIT     = 2'b00;
  localparam logic [1:0] GM_PLAY     = 2'b01;
  localparam logic [9:0] SPAWN_LEFT  = 10'(SPAWN_X);
  localparam logic [9:0] SPAWN_RIGHT = 10'(SPAWN_X + OBS_W);
  localparam logic [8:0] TOP_Y       = 9'(UPPER_BOUND);
  localparam logic [8:0] BOT_Y       = 9'(LOWER_BOUND);
  localparam logic [8:0] H_MIN       = 9'(OBS_H_MIN);
  localparam logic [7:0] INTERVAL    = 8'(SPAWN_INTERVAL);
  localparam logic [7:0] TIMER_HOLD  = 8'(SPAWN_INTERVAL - 1);
  localparam logic [4:0] BASE_SPEED  = 5'(SPEED);

  logic [1:0]           state;
  logic [3:0]           idx;
  logic [7:0]           timer;
  logic [15:0]          lfsr;
  logic [4:0]           speed;
  logic [9:0]           left_q  [NUM_SLOTS];
  logic [9:0]           right_q [NUM_SLOTS];
  logic [8:0]           top_q   [NUM_SLOTS];
  logic [8:0]           bot_q   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_valid;
  logic                 free_found;
  logic [3:0]           free_idx;
  logic [3:0]           valid_sum;
  logic [7:0]           timer_inc;
  logic                 spawn_due;
  logic                 init_req;
  logic [9:0]           step;
  logic [8:0]           height;

  assign init_req  = (gamemode == GM_INIT);
  assign timer_inc = timer + 8'd1;
  assign spawn_due = (state == SPAWN) && (timer_inc >= INTERVAL);
  assign step      = {5'd0, speed};
  assign height    = H_MIN + {3'd0, lfsr[5:0]};
  assign busy      = (state != IDLE);

  // Flatten the slot registers onto the packed output buses.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    obstacle_x = '0;
    obstacle_y = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      obstacle_x[k*20 +: 10]    = left_q[k];
      obstacle_x[k*20+10 +: 10] = right_q[k];
      obstacle_y[k*18 +: 9]     = top_q[k];
      obstacle_y[k*18+9 +: 9]   = bot_q[k];
    end
  end

  // Slot occupancy, lowest free slot and population count.
  always_comb begin
    slot_valid = '0;
    free_found = 1'b0;
    free_idx   = '0;
    valid_sum  = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_valid[k] = |{left_q[k], right_q[k], top_q[k], bot_q[k]};
      valid_sum     = valid_sum + {3'd0, slot_valid[k]};
    end
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!slot_valid[k]) begin
        free_found = 1'b1;
        free_idx   = 4'(k);
      end
    end
  end

  // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1); ignores game mode.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Scan/spawn sequencer and the obstacle table itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      timer         <= '0;
      overrun       <= 1'b0;
      spawned_total <= '0;
      // NOTE: the table is a small register file that must read as all-invalid, so it is reset explicitly.
      for (int k = 0; k < NUM_SLOTS; k++) begin
        left_q[k]  <= '0;
        right_q[k] <= '0;
        top_q[k]   <= '0;
        bot_q[k]   <= '0;
      end
    end else if (init_req) begin
      state         <= IDLE;
      idx           <= '0;
      timer         <= '0;
      overrun       <= 1'b0;
      spawned_total <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        left_q[k]  <= '0;
        right_q[k] <= '0;
        top_q[k]   <= '0;
        bot_q[k]   <= '0;
      end
    end else begin
      if (frame_tick && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick && (gamemode == GM_PLAY)) begin
            state <= SCAN;
            idx   <= '0;
          end
        end
        SCAN: begin
          if (slot_valid[idx]) begin
            if (right_q[idx] <= step) begin
              left_q[idx]  <= '0;
              right_q[idx] <= '0;
              top_q[idx]   <= '0;
              bot_q[idx]   <= '0;
            end else begin
              right_q[idx] <= right_q[idx] - step;
              left_q[idx]  <= (left_q[idx] < step) ? '0 : left_q[idx] - step;
            end
          end
          if (idx == 4'd9) state <= SPAWN;
          else             idx   <= idx + 4'd1;
        end
        SPAWN: begin
          state <= IDLE;
          if (!spawn_due) begin
            timer <= timer_inc;
          end else if (free_found) begin
            left_q[free_idx]  <= SPAWN_LEFT;
            right_q[free_idx] <= SPAWN_RIGHT;
            top_q[free_idx]   <= lfsr[15] ? BOT_Y - height : TOP_Y;
            bot_q[free_idx]   <= lfsr[15] ? BOT_Y : TOP_Y + height;
            timer             <= '0;
            if (spawned_total != 16'hFFFF) spawned_total <= spawned_total + 16'd1;
          end else begin
            // Table full: park just below the interval so the spawn retries next pass.
            timer <= TIMER_HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered population count, one cycle behind the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           active_count <= '0;
    else if (init_req) active_count <= '0;
    else               active_count <= valid_sum;
  end

`ifdef OBSTACLE_SPEEDUP_EN
  localparam logic [4:0] SPEED_CAP       = 5'(MAX_SPEED);
  localparam logic [7:0] SPAWNS_PER_STEP = 8'(SPEEDUP_SPAWNS);

  logic       spawn_fire;
  logic [7:0] speedup_cnt;

  assign spawn_fire = spawn_due && free_found && !init_req;

  // Raise the scroll speed every SPAWNS_PER_STEP successful spawns, up to SPEED_CAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed       <= BASE_SPEED;
      speedup_cnt <= '0;
    end else if (init_req) begin
      speed       <= BASE_SPEED;
      speedup_cnt <= '0;
    end else if (spawn_fire) begin
      if (speedup_cnt + 8'd1 >= SPAWNS_PER_STEP) begin
        speedup_cnt <= '0;
        if (speed < SPEED_CAP) speed <= speed + 5'd1;
      end else begin
        speedup_cnt <= speedup_cnt + 8'd1;
      end
    end
  end
`else
  localparam int unused_speedup_cfg = SPEEDUP_SPAWNS + MAX_SPEED;

  assign speed = BASE_SPEED;
`endif

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed passes through obstacle_scheduler. Each pass
// pushes its expected table/status into a scoreboard; a monitor pops and
// compares when busy drops. Spot values at key passes are checked by hand.
`timescale 1ns/1ps
module tb_obstacle_scheduler;

  localparam int SPAWN_X        = 600;
  localparam int OBS_W          = 41;   // right edge 641 reaches exactly 5 and then 1 at speed 4
  localparam int UPPER_BOUND    = 120;
  localparam int LOWER_BOUND    = 360;
  localparam int OBS_H_MIN      = 40;
  localparam int SPEED          = 4;
  localparam int SPAWN_INTERVAL = 6;    // short interval so the table fills quickly
  localparam int SPEEDUP_SPAWNS = 8;
  localparam int MAX_SPEED      = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_tick;
  logic [1:0]   gamemode;
  logic [199:0] obstacle_x;
  logic [179:0] obstacle_y;
  logic         busy;
  logic [3:0]   active_count;
  logic         overrun;
  logic [15:0]  spawned_total;

  always #5 clk = ~clk;

  obstacle_scheduler #(
    .SPAWN_X(SPAWN_X), .OBS_W(OBS_W), .UPPER_BOUND(UPPER_BOUND), .LOWER_BOUND(LOWER_BOUND),
    .OBS_H_MIN(OBS_H_MIN), .SPEED(SPEED), .SPAWN_INTERVAL(SPAWN_INTERVAL),
    .LFSR_SEED(16'hACE1), .SPEEDUP_SPAWNS(SPEEDUP_SPAWNS), .MAX_SPEED(MAX_SPEED)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y), .busy(busy),
    .active_count(active_count), .overrun(overrun), .spawned_total(spawned_total)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Reference LFSR, same polynomial and seed, stepping every cycle out of reset.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Pass-level reference model of the table.
  int m_left[10], m_right[10], m_top[10], m_bot[10];
  int m_timer, m_total, m_speed, m_sucnt;
  bit m_ovr;
  logic [15:0] spawn_lfsr;

  function automatic bit used(input int k);
    return (m_left[k] != 0) || (m_right[k] != 0) || (m_top[k] != 0) || (m_bot[k] != 0);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < 10; k++) if (used(k)) c++;
    return c;
  endfunction

  function automatic logic [199:0] exp_x();
    logic [199:0] v = '0;
    for (int k = 0; k < 10; k++) begin
      v[k*20 +: 10]    = 10'(m_left[k]);
      v[k*20+10 +: 10] = 10'(m_right[k]);
    end
    return v;
  endfunction

  function automatic logic [179:0] exp_y();
    logic [179:0] v = '0;
    for (int k = 0; k < 10; k++) begin
      v[k*18 +: 9]   = 9'(m_top[k]);
      v[k*18+9 +: 9] = 9'(m_bot[k]);
    end
    return v;
  endfunction

  task automatic model_init();
    for (int k = 0; k < 10; k++) begin
      m_left[k] = 0; m_right[k] = 0; m_top[k] = 0; m_bot[k] = 0;
    end
    m_timer = 0; m_total = 0; m_speed = SPEED; m_sucnt = 0; m_ovr = 1'b0;
  endtask

  task automatic model_pass(input logic [15:0] l);
    int fi;
    int h;
    for (int k = 0; k < 10; k++) begin
      if (used(k)) begin
        if (m_right[k] <= m_speed) begin
          m_left[k] = 0; m_right[k] = 0; m_top[k] = 0; m_bot[k] = 0;
        end else begin
          m_right[k] = m_right[k] - m_speed;
          m_left[k]  = (m_left[k] < m_speed) ? 0 : m_left[k] - m_speed;
        end
      end
    end
    m_timer++;
    if (m_timer >= SPAWN_INTERVAL) begin
      fi = -1;
      for (int k = 9; k >= 0; k--) if (!used(k)) fi = k;
      if (fi >= 0) begin
        h = OBS_H_MIN + int'(l[5:0]);
        m_left[fi]  = SPAWN_X;
        m_right[fi] = SPAWN_X + OBS_W;
        m_top[fi]   = l[15] ? LOWER_BOUND - h : UPPER_BOUND;
        m_bot[fi]   = l[15] ? LOWER_BOUND : UPPER_BOUND + h;
        m_timer     = 0;
        if (m_total < 65535) m_total++;
`ifdef OBSTACLE_SPEEDUP_EN
        m_sucnt++;
        if (m_sucnt >= SPEEDUP_SPAWNS) begin
          m_sucnt = 0;
          if (m_speed < MAX_SPEED) m_speed++;
        end
`endif
      end else begin
        m_timer = SPAWN_INTERVAL - 1;
      end
    end
  endtask

  typedef struct {
    string        name;
    logic [199:0] x;
    logic [179:0] y;
    logic [3:0]   cnt;
    logic [15:0]  tot;
    logic         ovr;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input string name);
    exp_t e;
    e.name = name;
    e.x    = exp_x();
    e.y    = exp_y();
    e.cnt  = 4'(m_count());
    e.tot  = 16'(m_total);
    e.ovr  = m_ovr;
    sb.push_back(e);
  endtask

  // Monitor: when busy drops, wait one cycle for active_count and compare.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy === 1'b1 && busy === 1'b0) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected_pass_end: got pass end, want none queued");
        end else begin
          e = sb.pop_front();
          check({e.name, "_x"},   obstacle_x,    e.x);
          check({e.name, "_y"},   obstacle_y,    e.y);
          check({e.name, "_cnt"}, active_count,  e.cnt);
          check({e.name, "_tot"}, spawned_total, e.tot);
          check({e.name, "_ovr"}, overrun,       e.ovr);
        end
      end
      prev_busy = busy;
    end
  end

  // One pass: tick in cycle T; optional second tick / pause at cycle T+c.
  task automatic do_pass(input string name, input int second_tick, input int pause_at,
                         input bit probe);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      frame_tick = (c == second_tick);
      if (c == pause_at) gamemode = 2'b10;
      if (probe && c == 2) begin
        check("retire_slot0_x", obstacle_x[19:0], 20'd0);
        check("retire_slot0_y", obstacle_y[17:0], 18'd0);
      end
      if (probe && c == 3) check("retire_count", active_count, 4'd9);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    spawn_lfsr = m_lfsr;  // LFSR value during the SPAWN cycle
    model_pass(spawn_lfsr);
    if (second_tick > 0) m_ovr = 1'b1;
    push_exp(name);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_spawn_slot0(input string name);
    int h;
    h = OBS_H_MIN + int'(spawn_lfsr[5:0]);
    check({name, "_left"},  obstacle_x[9:0],   10'd600);
    check({name, "_right"}, obstacle_x[19:10], 10'd641);
    check({name, "_top"},   obstacle_y[8:0],   spawn_lfsr[15] ? 9'(LOWER_BOUND - h) : 9'd120);
    check({name, "_bot"},   obstacle_y[17:9],  spawn_lfsr[15] ? 9'd360 : 9'(UPPER_BOUND + h));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_busy;
    bit probe_ok;
    rst = 1'b0; frame_tick = 1'b0; gamemode = 2'b00;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_init();
    @(negedge clk);
    check("reset_x",     obstacle_x,    200'd0);
    check("reset_y",     obstacle_y,    180'd0);
    check("reset_busy",  busy,          1'b0);
    check("reset_cnt",   active_count,  4'd0);
    check("reset_ovr",   overrun,       1'b0);
    check("reset_total", spawned_total, 16'd0);

    gamemode = 2'b01;
    @(negedge clk);
`ifdef OBSTACLE_SPEEDUP_EN
    probe_ok = 1'b0;
`else
    probe_ok = 1'b1;
`endif
    for (int p = 1; p <= 167; p++) begin
      do_pass($sformatf("pass%0d", p), 0, 0, probe_ok && (p == 167));
      if (p == 6) begin
        check_spawn_slot0("first_spawn");
        check("first_spawn_cnt",   active_count,  4'd1);
        check("first_spawn_total", spawned_total, 16'd1);
      end
      if (p == 7) begin
        check("scroll_left",  obstacle_x[9:0],   10'd596);
        check("scroll_right", obstacle_x[19:10], 10'd637);
      end
      if (p == 66) begin
        check("full_no_spawn_total", spawned_total, 16'd10);
        check("full_no_spawn_cnt",   active_count,  4'd10);
      end
      if (probe_ok && p == 166) begin
        check("edge_left",  obstacle_x[9:0],   10'd0);
        check("edge_right", obstacle_x[19:10], 10'd1);
      end
      if (probe_ok && p == 167) begin
        check_spawn_slot0("respawn");
        check("respawn_cnt",   active_count,  4'd10);
        check("respawn_total", spawned_total, 16'd11);
      end
    end

    // Tick 5 cycles into a pass: dropped, one scroll only, overrun sticks.
    do_pass("overrun", 5, 0, 1'b0);
    check("overrun_flag", overrun, 1'b1);

    // Pause requested mid-pass: the pass, including its spawn, completes.
    do_pass("pause_mid", 0, 3, 1'b0);

    // Paused and idle: ticks ignored, table frozen.
    saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("pause_busy", saw_busy,   1'b0);
    check("pause_x",    obstacle_x, exp_x());
    check("pause_y",    obstacle_y, exp_y());

    // Init in the middle of a scan (cycle T+5) clears everything next cycle.
    gamemode = 2'b01;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    gamemode = 2'b00;
    model_init();
    push_exp("init_abort");
    @(negedge clk);
    check("init_x",     obstacle_x,    200'd0);
    check("init_y",     obstacle_y,    180'd0);
    check("init_busy",  busy,          1'b0);
    check("init_ovr",   overrun,       1'b0);
    check("init_total", spawned_total, 16'd0);
    check("init_cnt",   active_count,  4'd0);
    repeat (3) @(negedge clk);

    gamemode = 2'b01;
    @(negedge clk);
    do_pass("post_init", 0, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_drained", 200'(sb.size()), 200'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
